// File: rtl/uart_autobaud_rx.sv
// uart_autobaud_rx
//   UART receiver that measures the baud rate from a 0x55 sync character,
//   locks onto the measured divider and then receives 8-bit frames
//   (optional parity, one stop bit).
//
// Parameters
//   FREQUENCY  system clock in Hz; sets the fastest accepted baud (FREQUENCY/8)
//   PARITY     "N" none, "E" even, "O" odd
//   CNTW       width of the measurement counter and the baud divider
//
// Ports
//   I_clk       clock, all logic on its rising edge
//   I_rst       synchronous active-high reset
//   I_rxd       asynchronous serial line, idle high
//   I_relock    single-cycle pulse: drop the lock and measure again
//   O_data      last received byte
//   O_valid     one-cycle pulse when O_data is updated
//   O_error     one-cycle pulse on parity/framing error or measurement abort
//   O_locked    high while a valid divider is held
//   O_baud_div  measured clock cycles per bit, 0 while unlocked
module uart_autobaud_rx #(
   parameter int             FREQUENCY = 50000000,
   parameter logic [7:0]     PARITY    = "N",
   parameter int             CNTW      = 20
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_rxd,
   input  logic              I_relock,
   output logic [7:0]        O_data,
   output logic              O_valid,
   output logic              O_error,
   output logic              O_locked,
   output logic [CNTW-1:0]   O_baud_div
);

   // Fastest supported baud is FREQUENCY/8, i.e. at least 8 clocks per bit.
   localparam int              MAX_BAUD   = FREQUENCY / 8;
   localparam int              MIN_DIV    = FREQUENCY / MAX_BAUD;
   localparam logic [CNTW-1:0] MIN_DIV_C  = CNTW'(MIN_DIV);
   localparam logic [CNTW-1:0] ONE_C      = CNTW'(1);
   localparam logic            HAS_PARITY = (PARITY != "N");
   localparam logic            ODD_PARITY = (PARITY == "O");

   typedef enum logic [2:0] {
      HUNT, MEASURE, SYNC_STOP, RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } state_t;

   state_t            state_q;
   logic              rx_meta_q, rx_line_q, rx_prev_q;
   logic [CNTW-1:0]   cnt_q, div_q, baud_div_q;
   logic [2:0]        edge_cnt_q, bit_cnt_q;
   logic [7:0]        shift_q, data_q;
   logic              err_flag_q, valid_q, error_q, locked_q;

   logic              fall_d;
   logic [CNTW-1:0]   cnt_inc_d, meas_div_d, half_d, sync_tgt_d;
   logic              par_exp_d;

   assign fall_d     = rx_prev_q & ~rx_line_q;
   assign cnt_inc_d  = cnt_q + ONE_C;
   // The edge cycle itself belongs to the span, so use the incremented count.
   assign meas_div_d = cnt_inc_d >> 3;
   assign half_d     = div_q >> 1;
   assign sync_tgt_d = div_q + half_d;
   assign par_exp_d  = (^shift_q) ^ ODD_PARITY;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q    <= HUNT;
         rx_meta_q  <= 1'b1;
         rx_line_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         cnt_q      <= '0;
         div_q      <= '0;
         baud_div_q <= '0;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         err_flag_q <= 1'b0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         rx_meta_q <= I_rxd;
         rx_line_q <= rx_meta_q;
         rx_prev_q <= rx_line_q;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;

         if (I_relock) begin
            // Pulses are cleared above, so an in-flight frame never reports.
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            baud_div_q <= '0;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            err_flag_q <= 1'b0;
         end else begin
            case (state_q)
               HUNT: begin
                  locked_q   <= 1'b0;
                  baud_div_q <= '0;
                  if (fall_d) begin
                     cnt_q      <= '0;
                     edge_cnt_q <= '0;
                     state_q    <= MEASURE;
                  end
               end
               MEASURE: begin
                  cnt_q <= cnt_inc_d;
                  if (&cnt_q) begin
                     error_q <= 1'b1;
                     state_q <= HUNT;
                  end else if (fall_d) begin
                     // The first edge was consumed in HUNT; this is edge 2..5.
                     if (edge_cnt_q == 3'd3) begin
                        if (meas_div_d < MIN_DIV_C) begin
                           error_q <= 1'b1;
                           state_q <= HUNT;
                        end else begin
                           div_q   <= meas_div_d;
                           cnt_q   <= '0;
                           state_q <= SYNC_STOP;
                        end
                     end else begin
                        edge_cnt_q <= edge_cnt_q + 3'd1;
                     end
                  end
               end
               SYNC_STOP: begin
                  // Fifth edge starts bit 7; 1.5 bits later is mid stop bit.
                  cnt_q <= cnt_inc_d;
                  if (cnt_q == sync_tgt_d) begin
                     cnt_q <= '0;
                     if (rx_line_q) begin
                        locked_q   <= 1'b1;
                        baud_div_q <= div_q;
                        state_q    <= RX_IDLE;
                     end else begin
                        error_q <= 1'b1;
                        state_q <= HUNT;
                     end
                  end
               end
               RX_IDLE: begin
                  // Edge detection needs a high line first, so a low stop
                  // bit holds us here until the line recovers.
                  if (fall_d) begin
                     cnt_q      <= '0;
                     bit_cnt_q  <= '0;
                     err_flag_q <= 1'b0;
                     state_q    <= RX_START;
                  end
               end
               RX_START: begin
                  cnt_q <= cnt_inc_d;
                  if (cnt_q == half_d) begin
                     cnt_q   <= '0;
                     state_q <= rx_line_q ? RX_IDLE : RX_DATA;
                  end
               end
               RX_DATA: begin
                  cnt_q <= cnt_inc_d;
                  if (cnt_q == div_q - ONE_C) begin
                     cnt_q     <= '0;
                     shift_q   <= {rx_line_q, shift_q[7:1]};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7)
                        state_q <= HAS_PARITY ? RX_PARITY : RX_STOP;
                  end
               end
               RX_PARITY: begin
                  cnt_q <= cnt_inc_d;
                  if (cnt_q == div_q - ONE_C) begin
                     cnt_q <= '0;
                     if (rx_line_q != par_exp_d)
                        err_flag_q <= 1'b1;
                     state_q <= RX_STOP;
                  end
               end
               RX_STOP: begin
                  cnt_q <= cnt_inc_d;
                  if (cnt_q == div_q - ONE_C) begin
                     cnt_q   <= '0;
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     error_q <= err_flag_q | ~rx_line_q;
                     state_q <= RX_IDLE;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign O_data     = data_q;
   assign O_valid    = valid_q;
   assign O_error    = error_q;
   assign O_locked   = locked_q;
   assign O_baud_div = baud_div_q;

endmodule
